// File: rtl/jk_seq_pkg.sv
// Shared encodings and defaults for the JK command sequencer.
package jk_seq_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_LEN_W = 4;

  // Command opcode is the {j,k} pair driven to the flip-flop.
  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguishable with DEPTH entries in use.
// Handshake: a push is taken only when !full, a pop only when !empty;
// flush wins over both and empties the FIFO on the next edge.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_push;
  logic         w_pop;

  assign w_push = push && !full && !flush;
  assign w_pop  = pop && !empty && !flush;
  assign full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign empty  = (r_wptr == r_rptr);
  assign level  = r_wptr - r_rptr;
  assign rdata  = r_mem[r_rptr[AW-1:0]];

  // Storage write; contents are don't-care until a pointer covers them.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

  // Pointer update with flush clearing both pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Buffers JK commands and drives the j/k inputs of a master-slave JK
// flip-flop, holding each command for cmd_len+1 cycles.
// Handshake: a command is accepted on a posedge where cmd_valid && cmd_ready
// && !flush; cmd_ready is simply !full (no bypass when a pop coincides).
module jk_cmd_sequencer
  import jk_seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [LEN_W-1:0]       cmd_len,
  output logic                   j,
  output logic                   k,
  output logic                   busy,
  output logic                   last_cycle,
  output logic [$clog2(DEPTH):0] fifo_level,
  output state_t                 o_dbg_state
);

  localparam int CW = LEN_W + 2;

  state_t           r_state;
  logic [LEN_W-1:0] r_remain;
  logic             r_j;
  logic             r_k;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic [CW-1:0]    w_head;
  logic [1:0]       w_head_op;
  logic [LEN_W-1:0] w_head_len;

  assign w_head_op  = w_head[CW-1:LEN_W];
  assign w_head_len = w_head[LEN_W-1:0];

  // Pop whenever the sequencer is free to take the next command this edge.
  assign w_pop = !flush && !w_empty &&
                 ((r_state == ST_IDLE) || (r_remain == '0));

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (cmd_valid),
    .pop   (w_pop),
    .wdata ({cmd_op, cmd_len}),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  // Sequencer FSM: load from FIFO head, count down, chain or go idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_remain <= '0;
      r_j      <= 1'b0;
      r_k      <= 1'b0;
    end else if (flush) begin
      r_state  <= ST_IDLE;
      r_remain <= '0;
      r_j      <= 1'b0;
      r_k      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_state      <= ST_RUN;
            {r_j, r_k}   <= w_head_op;
            r_remain     <= w_head_len;
          end else begin
            r_j <= 1'b0;
            r_k <= 1'b0;
          end
        end
        ST_RUN: begin
          if (r_remain != '0) begin
            r_remain <= r_remain - 1'b1;
          end else if (!w_empty) begin
            {r_j, r_k} <= w_head_op;
            r_remain   <= w_head_len;
          end else begin
            r_state <= ST_IDLE;
            r_j     <= 1'b0;
            r_k     <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_remain <= '0;
          r_j      <= 1'b0;
          r_k      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = !w_full;
  assign j           = r_j;
  assign k           = r_k;
  assign busy        = (r_state == ST_RUN);
  assign last_cycle  = (r_state == ST_RUN) && (r_remain == '0);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_jk_cmd_sequencer;
  import jk_seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int LEN_W = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             cmd_ready;
  logic             j;
  logic             k;
  logic             busy;
  logic             last_cycle;
  logic [LW-1:0]    fifo_level;
  state_t           dbg_state;

  always #5 clk = ~clk;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_len     (cmd_len),
    .j           (j),
    .k           (k),
    .busy        (busy),
    .last_cycle  (last_cycle),
    .fifo_level  (fifo_level),
    .o_dbg_state (dbg_state)
  );

  // Behavioural master-slave JK flip-flop fed by the sequencer.
  logic q;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: queued commands plus the command in flight.
  logic [LEN_W+1:0] exp_q[$];
  bit               m_active;
  int               m_left;
  logic [1:0]       m_op;

  task automatic model_clear();
    exp_q.delete();
    m_active = 0;
    m_left   = 0;
    m_op     = 2'b00;
  endtask

  // Advance the model across one edge using the inputs currently applied.
  task automatic model_step();
    bit               accept;
    logic [LEN_W+1:0] head;
    accept = cmd_valid && (exp_q.size() < DEPTH);
    if (flush) begin
      exp_q.delete();
      m_active = 0;
    end else begin
      if (m_active) begin
        m_left--;
        if (m_left == 0) m_active = 0;
      end
      if (!m_active && exp_q.size() > 0) begin
        head     = exp_q.pop_front();
        m_active = 1;
        m_op     = head[LEN_W+1:LEN_W];
        m_left   = int'(head[LEN_W-1:0]) + 1;
      end
      if (accept) exp_q.push_back({cmd_op, cmd_len});
    end
  endtask

  task automatic model_compare(input string name);
    logic [8:0] exp_v;
    logic [8:0] act_v;
    logic [LW-1:0] lvl;
    lvl   = LW'(exp_q.size());
    exp_v = {m_active ? m_op : 2'b00, m_active, (m_active && m_left == 1),
             (exp_q.size() < DEPTH), lvl, m_active};
    act_v = {j, k, busy, last_cycle, cmd_ready, fifo_level, (dbg_state == ST_RUN)};
    check(name, 32'(act_v), 32'(exp_v));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0;
    flush     = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = '0;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [LEN_W-1:0] len);
    cmd_valid = v;
    cmd_op    = op;
    cmd_len   = len;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_clear();
  endtask

  function automatic logic [7:0] outs();
    return {j, k, busy, last_cycle, cmd_ready, fifo_level};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic             valid;
    logic [1:0]       op;
    logic [LEN_W-1:0] len;
    logic             fl;
    logic [7:0]       exp;   // {j,k,busy,last,ready,level[2:0]} after the edge
  } vec_t;

  vec_t vecs[11];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int         cnt;
    int         lasts;
    int         lvl_max;
    bit         seen;
    logic [1:0] fill_ops[4];
    logic       q_exp[4];
    logic       q_seen[$];

    // SET len=0, then TOGGLE len=3 chased by CLEAR len=1.
    vecs[0]  = '{1'b1, 2'b10, 4'd0, 1'b0, 8'b0000_1001};
    vecs[1]  = '{1'b0, 2'b00, 4'd0, 1'b0, 8'b1011_1000};
    vecs[2]  = '{1'b0, 2'b00, 4'd0, 1'b0, 8'b0000_1000};
    vecs[3]  = '{1'b1, 2'b11, 4'd3, 1'b0, 8'b0000_1001};
    vecs[4]  = '{1'b1, 2'b01, 4'd1, 1'b0, 8'b1110_1001};
    vecs[5]  = '{1'b0, 2'b00, 4'd0, 1'b0, 8'b1110_1001};
    vecs[6]  = '{1'b0, 2'b00, 4'd0, 1'b0, 8'b1110_1001};
    vecs[7]  = '{1'b0, 2'b00, 4'd0, 1'b0, 8'b1111_1001};
    vecs[8]  = '{1'b0, 2'b00, 4'd0, 1'b0, 8'b0110_1000};
    vecs[9]  = '{1'b0, 2'b00, 4'd0, 1'b0, 8'b0111_1000};
    vecs[10] = '{1'b0, 2'b00, 4'd0, 1'b0, 8'b0000_1000};

    // Reset values while rst_n is low.
    idle_inputs();
    #12;
    check("reset_outs", 32'(outs()), 32'h08);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      cmd_valid = vecs[i].valid;
      cmd_op    = vecs[i].op;
      cmd_len   = vecs[i].len;
      flush     = vecs[i].fl;
      tick();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    idle_inputs();

    // Longest run length lasts 2^LEN_W cycles with a single last_cycle.
    do_reset();
    drive(1'b1, OP_TOGGLE, 4'd15);
    tick();
    idle_inputs();
    cnt = 0;
    lasts = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!busy) break;
      if (j && k) cnt++;
      if (last_cycle) lasts++;
    end
    check("maxlen_cycles", 32'(cnt), 32'd16);
    check("maxlen_last", 32'(lasts), 32'd1);

    // Fill the FIFO behind a long HOLD: back-pressure and no bypass.
    do_reset();
    drive(1'b1, OP_HOLD, 4'd15);
    tick();
    idle_inputs();
    tick();
    check("hold_busy", 32'({busy, j, k}), 32'b100);
    fill_ops = '{OP_TOGGLE, OP_CLEAR, OP_SET, OP_TOGGLE};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fill_ops[i], 4'd3);
      tick();
    end
    check("fill_ready", 32'(cmd_ready), 32'd0);
    check("fill_level", 32'(fifo_level), 32'd4);
    drive(1'b1, OP_SET, 4'd0);
    lvl_max = 0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
      if (cmd_ready) begin
        seen = 1;
        break;
      end
    end
    check("fill_lvl_max", 32'(lvl_max), 32'd4);
    check("fill_pop_seen", 32'(seen), 32'd1);
    check("fill_after_pop", 32'({j, k, busy, fifo_level}), 32'({2'b11, 1'b1, 3'd3}));
    tick();
    check("fill_fifth", 32'(fifo_level), 32'd4);
    idle_inputs();

    // Flush mid-run with three queued; simultaneous push is dropped.
    do_reset();
    drive(1'b1, OP_SET, 4'd5);
    tick();
    drive(1'b1, OP_CLEAR, 4'd1);
    tick();
    tick();
    tick();
    check("flush_pre", 32'({busy, fifo_level}), 32'({1'b1, 3'd3}));
    drive(1'b1, OP_TOGGLE, 4'd2);
    flush = 1'b1;
    tick();
    check("flush_outs", 32'(outs()), 32'h08);
    idle_inputs();
    tick();
    check("flush_dropped", 32'(outs()), 32'h08);

    // Asynchronous reset between edges aborts the run and queue.
    do_reset();
    drive(1'b1, OP_SET, 4'd10);
    tick();
    drive(1'b1, OP_TOGGLE, 4'd2);
    tick();
    drive(1'b1, OP_CLEAR, 4'd2);
    tick();
    idle_inputs();
    tick();
    check("arst_pre", 32'({j, k, busy, fifo_level}), 32'({2'b10, 1'b1, 3'd2}));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_outs", 32'(outs()), 32'h08);
    #2;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy || j || k || fifo_level != 0) cnt++;
    end
    check("arst_no_stale", 32'(cnt), 32'd0);

    // Connected JK flip-flop: SET, TOGGLE len=1, CLEAR.
    do_reset();
    q_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
    drive(1'b1, OP_SET, 4'd0);
    tick();
    drive(1'b1, OP_TOGGLE, 4'd1);
    tick();
    drive(1'b1, OP_CLEAR, 4'd0);
    @(negedge clk); #1; q_seen.push_back(q);
    tick();
    idle_inputs();
    @(negedge clk); #1; q_seen.push_back(q);
    tick();
    @(negedge clk); #1; q_seen.push_back(q);
    tick();
    @(negedge clk); #1; q_seen.push_back(q);
    for (int i = 0; i < 4; i++)
      check($sformatf("jkff_q%0d", i), 32'(q_seen[i]), 32'(q_exp[i]));

    // Randomized traffic against the reference model.
    do_reset();
    model_compare("rand_init");
    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(0, 99) < 60);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_len   = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom_range(0, 15))
                                              : LEN_W'($urandom_range(0, 2));
      flush     = ($urandom_range(0, 39) == 0);
      model_step();
      tick();
      model_compare($sformatf("rand%0d", i));
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
